switch_debounce_array: RTL and testbench

SWITCH_DEBOUNCE_ARRAY -- requirements
Module: switch_debounce_array

---
 rtl/switch_debounce_array_if.sv | 21 ++
 rtl/switch_debounce_array.sv | 105 ++++++++++
 tb/tb_switch_debounce_array.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/switch_debounce_array_if.sv
// Switch bundle between a debouncer and its consumer: raw levels in, conditioned levels and pulses out.
interface switch_debounce_array_if #(
  parameter int NUM_CH = 4
);
  logic [NUM_CH-1:0] i_Switch;
  logic [NUM_CH-1:0] o_Level;
  logic [NUM_CH-1:0] o_Rise;
  logic [NUM_CH-1:0] o_Fall;
  logic [NUM_CH-1:0] o_Toggle;
  logic [NUM_CH-1:0] o_Hold;

  modport master (
    output i_Switch,
    input  o_Level, o_Rise, o_Fall, o_Toggle, o_Hold
  );

  modport slave (
    input  i_Switch,
    output o_Level, o_Rise, o_Fall, o_Toggle, o_Hold
  );
endinterface

// File: rtl/switch_debounce_array.sv
// Per-channel switch conditioner: 2-flop sync, debounce counter, edge/toggle/hold pulses.
// Latency: level follows a clean step DEBOUNCE_LIMIT+1 edges after first sampling; no backpressure, every output registered.
module switch_debounce_array #(
  parameter int NUM_CH          = 4,
  parameter int DEBOUNCE_LIMIT  = 250000,
  parameter int HOLD_LIMIT      = 25000000,
  parameter int TOGGLE_ON_PRESS = 0
) (
  input  logic                    i_Clk,
  input  logic                    i_Reset,
  switch_debounce_array_if.slave  sw
);

  localparam int DB_W = $clog2(DEBOUNCE_LIMIT);
  localparam int HD_W = $clog2(HOLD_LIMIT);
  localparam logic [DB_W-1:0] DB_MAX = DB_W'(DEBOUNCE_LIMIT - 1);
  localparam logic [HD_W-1:0] HD_MAX = HD_W'(HOLD_LIMIT - 1);

  logic [NUM_CH-1:0] sync1_q, sync1_d;
  logic [NUM_CH-1:0] sync2_q, sync2_d;
  logic [NUM_CH-1:0] level_q, level_d;
  logic [NUM_CH-1:0] rise_q, rise_d;
  logic [NUM_CH-1:0] fall_q, fall_d;
  logic [NUM_CH-1:0] toggle_q, toggle_d;
  logic [NUM_CH-1:0] hold_q, hold_d;
  logic [NUM_CH-1:0] fired_q, fired_d;
  logic [DB_W-1:0]   db_cnt_q [NUM_CH];
  logic [DB_W-1:0]   db_cnt_d [NUM_CH];
  logic [HD_W-1:0]   hd_cnt_q [NUM_CH];
  logic [HD_W-1:0]   hd_cnt_d [NUM_CH];

  always_comb begin
    sync1_d  = sw.i_Switch;
    sync2_d  = sync1_q;
    level_d  = level_q;
    rise_d   = '0;
    fall_d   = '0;
    toggle_d = toggle_q;
    hold_d   = '0;
    fired_d  = fired_q;
    for (int i = 0; i < NUM_CH; i++) begin
      db_cnt_d[i] = '0;
      hd_cnt_d[i] = hd_cnt_q[i];
      if (sync2_q[i] != level_q[i]) begin
        if (db_cnt_q[i] == DB_MAX) begin
          level_d[i] = sync2_q[i];
          rise_d[i]  = sync2_q[i];
          fall_d[i]  = ~sync2_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + 1'b1;
        end
      end
      if ((TOGGLE_ON_PRESS != 0) ? rise_d[i] : fall_d[i]) begin
        toggle_d[i] = ~toggle_q[i];
      end
      // Counter parks at its max; fired_q keeps the pulse to one per press.
      if (!level_q[i]) begin
        hd_cnt_d[i] = '0;
        fired_d[i]  = 1'b0;
      end else if (hd_cnt_q[i] != HD_MAX) begin
        hd_cnt_d[i] = hd_cnt_q[i] + 1'b1;
      end else if (!fired_q[i]) begin
        hold_d[i]  = 1'b1;
        fired_d[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      level_q  <= '0;
      rise_q   <= '0;
      fall_q   <= '0;
      toggle_q <= '0;
      hold_q   <= '0;
      fired_q  <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        db_cnt_q[i] <= '0;
        hd_cnt_q[i] <= '0;
      end
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      level_q  <= level_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      toggle_q <= toggle_d;
      hold_q   <= hold_d;
      fired_q  <= fired_d;
      for (int i = 0; i < NUM_CH; i++) begin
        db_cnt_q[i] <= db_cnt_d[i];
        hd_cnt_q[i] <= hd_cnt_d[i];
      end
    end
  end

  assign sw.o_Level  = level_q;
  assign sw.o_Rise   = rise_q;
  assign sw.o_Fall   = fall_q;
  assign sw.o_Toggle = toggle_q;
  assign sw.o_Hold   = hold_q;

endmodule

// File: tb/tb_switch_debounce_array.sv
// Drives two debouncers (toggle on release / on press) with directed and random switch traffic;
// a history-based model predicts every cycle's outputs into a queue that a monitor drains.
module tb_switch_debounce_array;
  localparam int NC   = 2;
  localparam int L    = 4;
  localparam int H    = 8;
  localparam int MAXC = 2400;

  typedef struct packed {
    logic [NC-1:0] level;
    logic [NC-1:0] rise;
    logic [NC-1:0] fall;
    logic [NC-1:0] tog0;
    logic [NC-1:0] tog1;
    logic [NC-1:0] hold;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  switch_debounce_array_if #(.NUM_CH(NC)) bus_a ();
  switch_debounce_array_if #(.NUM_CH(NC)) bus_b ();

  switch_debounce_array #(.NUM_CH(NC), .DEBOUNCE_LIMIT(L), .HOLD_LIMIT(H), .TOGGLE_ON_PRESS(0))
    dut_a (.i_Clk(clk), .i_Reset(rst), .sw(bus_a));
  switch_debounce_array #(.NUM_CH(NC), .DEBOUNCE_LIMIT(L), .HOLD_LIMIT(H), .TOGGLE_ON_PRESS(1))
    dut_b (.i_Clk(clk), .i_Reset(rst), .sw(bus_b));

  exp_t exp_q[$];
  int   tests  = 0;
  int   failed = 0;
  int   n      = 0;
  int   last_rst = 0;
  bit   armed  = 0;
  bit   done   = 0;

  // Per-edge history: values held after rising edge number idx.
  logic [NC-1:0] s1_h [MAXC];
  logic [NC-1:0] s2_h [MAXC];
  logic [NC-1:0] lvl_h [MAXC];
  logic [NC-1:0] rise_h [MAXC];
  logic [NC-1:0] fall_h [MAXC];
  logic [NC-1:0] tog0_h [MAXC];
  logic [NC-1:0] tog1_h [MAXC];
  logic [NC-1:0] hold_h [MAXC];

  task automatic model(input logic r, input logic [NC-1:0] x);
    exp_t e;
    logic [NC-1:0] pl, pt0, pt1;
    bit stable, held;
    pl  = (n > 0) ? lvl_h[n-1]  : '0;
    pt0 = (n > 0) ? tog0_h[n-1] : '0;
    pt1 = (n > 0) ? tog1_h[n-1] : '0;
    s1_h[n] = '0; s2_h[n] = '0; lvl_h[n] = '0; rise_h[n] = '0;
    fall_h[n] = '0; tog0_h[n] = '0; tog1_h[n] = '0; hold_h[n] = '0;
    if (r) begin
      last_rst = n;
    end else begin
      s1_h[n]  = x;
      s2_h[n]  = (n > 0) ? s1_h[n-1] : '0;
      lvl_h[n] = pl;
      for (int i = 0; i < NC; i++) begin
        // Accept when the synchronised input disagreed with the level for L consecutive edges since reset.
        stable = (n - L + 1 > last_rst);
        for (int k = 0; k < L; k++)
          if (stable && s2_h[n-1-k][i] == pl[i]) stable = 0;
        if (stable) begin
          lvl_h[n][i]  = ~pl[i];
          rise_h[n][i] = ~pl[i];
          fall_h[n][i] = pl[i];
        end
        held = (n - H > last_rst) && rise_h[(n - H > 0) ? n - H : 0][i];
        if (held)
          for (int j = n - H; j < n; j++)
            if (!lvl_h[j][i]) held = 0;
        hold_h[n][i] = held;
      end
      tog0_h[n] = pt0 ^ fall_h[n];
      tog1_h[n] = pt1 ^ rise_h[n];
    end
    e.level = lvl_h[n]; e.rise = rise_h[n]; e.fall = fall_h[n];
    e.tog0  = tog0_h[n]; e.tog1 = tog1_h[n]; e.hold = hold_h[n];
    exp_q.push_back(e);
    armed = 1;
  endtask

  task automatic step(input logic r, input logic [NC-1:0] x);
    @(negedge clk);
    rst = r;
    bus_a.i_Switch = x;
    bus_b.i_Switch = x;
    if (n < MAXC) begin
      model(r, x);
      n++;
    end
  endtask

  task automatic run(input logic r, input logic [NC-1:0] x, input int cycles);
    for (int c = 0; c < cycles; c++) step(r, x);
  endtask

  // Monitor: every cycle is an output beat for this block.
  initial begin
    exp_t e;
    logic [5*NC-1:0] act, req;
    forever begin
      @(posedge clk);
      #1;
      if (done) continue;
      if (exp_q.size() == 0) begin
        if (armed) begin
          tests++; failed++;
          $display("FAIL queue_underflow at t=%0t: no expected entry", $time);
        end
        continue;
      end
      e = exp_q.pop_front();
      act = {bus_a.o_Level, bus_a.o_Rise, bus_a.o_Fall, bus_a.o_Toggle, bus_a.o_Hold};
      req = {e.level, e.rise, e.fall, e.tog0, e.hold};
      tests++;
      if (act !== req) begin
        failed++;
        $display("FAIL dut_release_toggle t=%0t lvl/rise/fall/tog/hold got %b required %b", $time, act, req);
      end
      act = {bus_b.o_Level, bus_b.o_Rise, bus_b.o_Fall, bus_b.o_Toggle, bus_b.o_Hold};
      req = {e.level, e.rise, e.fall, e.tog1, e.hold};
      tests++;
      if (act !== req) begin
        failed++;
        $display("FAIL dut_press_toggle t=%0t lvl/rise/fall/tog/hold got %b required %b", $time, act, req);
      end
    end
  end

  initial begin
    int run_left [NC];
    logic [NC-1:0] cur;
    bus_a.i_Switch = '0;
    bus_b.i_Switch = '0;
    run(1'b1, 2'b00, 3);
    run(1'b0, 2'b00, 4);
    // Clean press held 20 then release, twice: level, hold pulse, toggle both polarities.
    for (int rep = 0; rep < 2; rep++) begin
      run(1'b0, 2'b01, 20);
      run(1'b0, 2'b00, 14);
    end
    // Short glitch on ch1, then a long-enough press.
    run(1'b0, 2'b10, 3);
    run(1'b0, 2'b00, 8);
    run(1'b0, 2'b10, 12);
    run(1'b0, 2'b00, 12);
    // Both channels pressed on the same cycle.
    run(1'b0, 2'b11, 16);
    run(1'b0, 2'b00, 14);
    // Press too short for a hold pulse.
    run(1'b0, 2'b01, 6);
    run(1'b0, 2'b00, 12);
    // Reset in the middle of a debounce with the switch held high.
    run(1'b0, 2'b11, 4);
    run(1'b1, 2'b11, 1);
    run(1'b0, 2'b11, 20);
    // Reset in the middle of a hold count.
    run(1'b1, 2'b11, 1);
    run(1'b0, 2'b11, 10);
    run(1'b1, 2'b00, 2);
    run(1'b0, 2'b00, 8);
    // Random runs: mostly long enough to be accepted, some glitches, rare resets.
    cur = '0;
    for (int i = 0; i < NC; i++) run_left[i] = 0;
    for (int c = 0; c < 1600; c++) begin
      for (int i = 0; i < NC; i++) begin
        if (run_left[i] == 0) begin
          cur[i] = ~cur[i];
          run_left[i] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3))
                                                    : int'($urandom_range(4, 14));
        end
        run_left[i]--;
      end
      step(($urandom_range(0, 249) == 0), cur);
    end
    run(1'b0, 2'b00, 10);
    @(posedge clk);
    #2;
    done = 1;
    tests++;
    if (exp_q.size() != 0) begin
      failed++;
      $display("FAIL queue_drain: %0d entries left, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
